hazard_ctrl: RTL and testbench

Pipeline interlock and sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It tracks destination registers of the instructions in EX/MEM/WB, stalls or bubbles the instruction in decode on read-after-write hazards, and produces registered forwarding selects for EX. It also flushes on control-flow redirects and drains and halts the pipeline on EBREAK or an illegal instruction. It sits beside the decode stage and consumes its retire-address outputs, which read as zero when a register is unused.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/hz_scoreboard.sv | 83 ++++++++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline control blocks: forward-select codes,
// halt FSM encoding, trap causes and the register-match helpers used by the hazard logic.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } halt_state_e;

    localparam logic CAUSE_EBREAK  = 1'b0;
    localparam logic CAUSE_ILLEGAL = 1'b1;

    // Index of the last drain cycle; the counter starts at 0 on trap detection.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return (dst != 5'd0) && ((dst == rs1) || (dst == rs2));
    endfunction

    // A load in EX cannot forward yet (the stall covers it), so it falls through to the MEM check.
    function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                              input logic [4:0] ex_rd,
                                              input logic       ex_load,
                                              input logic [4:0] mem_rd);
        if (rs != 5'd0 && rs == ex_rd && !ex_load) begin
            return FWD_MEM;
        end else if (rs != 5'd0 && rs == mem_rd) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Destination-register trackers for EX/MEM/WB, RAW hazard detection against the
// instruction in decode, and the registered EX operand forward selects.
module hz_scoreboard
    import core_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_id_valid,
    input  logic [4:0] i_rs1_raddr,
    input  logic [4:0] i_rs2_raddr,
    input  logic [4:0] i_rd_waddr,
    input  logic       i_mem_read,
    input  logic       i_ex_bubble,
    output logic       o_hz,
    output logic [1:0] o_fwd_rs1,
    output logic [1:0] o_fwd_rs2,
    output logic       o_empty
);

    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_load_q, ex_load_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic [1:0] fwd_rs1_q, fwd_rs1_d;
    logic [1:0] fwd_rs2_q, fwd_rs2_d;

    logic       hz;
    logic [1:0] fwd_rs1_sel;
    logic [1:0] fwd_rs2_sel;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        hz          = 1'b0;
        fwd_rs1_sel = FWD_RF;
        fwd_rs2_sel = FWD_RF;
        if (BYPASS_EN) begin
            hz          = i_id_valid && ex_load_q && reg_match(ex_rd_q, i_rs1_raddr, i_rs2_raddr);
            fwd_rs1_sel = fwd_select(i_rs1_raddr, ex_rd_q, ex_load_q, mem_rd_q);
            fwd_rs2_sel = fwd_select(i_rs2_raddr, ex_rd_q, ex_load_q, mem_rd_q);
        end else begin
            // No bypass and no RF write-through: wait until the producer has left WB.
            hz = i_id_valid && (reg_match(ex_rd_q,  i_rs1_raddr, i_rs2_raddr) ||
                                reg_match(mem_rd_q, i_rs1_raddr, i_rs2_raddr) ||
                                reg_match(wb_rd_q,  i_rs1_raddr, i_rs2_raddr));
        end
    end

    always_comb begin
        ex_rd_d   = i_ex_bubble ? 5'd0 : i_rd_waddr;
        ex_load_d = !i_ex_bubble && i_mem_read;
        mem_rd_d  = ex_rd_q;
        wb_rd_d   = mem_rd_q;
        fwd_rs1_d = i_ex_bubble ? FWD_RF : fwd_rs1_sel;
        fwd_rs2_d = i_ex_bubble ? FWD_RF : fwd_rs2_sel;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_rd_q   <= 5'd0;
            ex_load_q <= 1'b0;
            mem_rd_q  <= 5'd0;
            wb_rd_q   <= 5'd0;
            fwd_rs1_q <= FWD_RF;
            fwd_rs2_q <= FWD_RF;
        end else begin
            // NOTE: non-blocking updates let the whole tracker shift in one edge without ordering hazards.
            ex_rd_q   <= ex_rd_d;
            ex_load_q <= ex_load_d;
            mem_rd_q  <= mem_rd_d;
            wb_rd_q   <= wb_rd_d;
            fwd_rs1_q <= fwd_rs1_d;
            fwd_rs2_q <= fwd_rs2_d;
        end
    end

    assign o_hz      = hz;
    assign o_fwd_rs1 = fwd_rs1_q;
    assign o_fwd_rs2 = fwd_rs2_q;
    assign o_empty   = (ex_rd_q == 5'd0) && (mem_rd_q == 5'd0) && (wb_rd_q == 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: stalls/bubbles decode on RAW hazards, flushes on
// redirects, and drains then halts the pipeline on EBREAK or an illegal instruction.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic [4:0]  i_rs1_raddr,
    input  logic [4:0]  i_rs2_raddr,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_mem_read,
    input  logic        i_illegal,
    input  logic        i_ebreak,
    input  logic        i_redirect,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_ex_bubble,
    output logic [1:0]  o_fwd_rs1,
    output logic [1:0]  o_fwd_rs2,
    output logic        o_halted,
    output logic        o_trap_cause,
    output logic [31:0] o_stall_cycles
);

    halt_state_e state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic        cause_q, cause_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic hz;
    logic sb_empty;
    logic stall;
    logic flush;
    logic ex_bubble;

    hz_scoreboard #(
        .BYPASS_EN (BYPASS_EN)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_id_valid  (i_id_valid),
        .i_rs1_raddr (i_rs1_raddr),
        .i_rs2_raddr (i_rs2_raddr),
        .i_rd_waddr  (i_rd_waddr),
        .i_mem_read  (i_mem_read),
        .i_ex_bubble (ex_bubble),
        .o_hz        (hz),
        .o_fwd_rs1   (o_fwd_rs1),
        .o_fwd_rs2   (o_fwd_rs2),
        .o_empty     (sb_empty)
    );

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        cause_d     = cause_q;
        stall       = 1'b0;
        flush       = 1'b0;
        ex_bubble   = !i_id_valid;

        unique case (state_q)
            RUN: begin
                if (i_redirect) begin
                    flush     = 1'b1;
                    ex_bubble = 1'b1;
                end else if (i_id_valid && (i_ebreak || i_illegal) && !hz) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 2'd0;
                    cause_d     = i_illegal ? CAUSE_ILLEGAL : CAUSE_EBREAK;
                    ex_bubble   = 1'b1;
                end else if (hz) begin
                    stall     = 1'b1;
                    ex_bubble = 1'b1;
                end
            end
            DRAIN: begin
                ex_bubble = 1'b1;
                if (i_redirect) begin
                    // The trap was on a mispredicted path; resume normal issue.
                    state_d     = RUN;
                    drain_cnt_d = 2'd0;
                    flush       = 1'b1;
                end else begin
                    stall = 1'b1;
                    if (drain_cnt_q == DRAIN_LAST && sb_empty) begin
                        state_d = HALTED;
                    end else if (drain_cnt_q != DRAIN_LAST) begin
                        drain_cnt_d = drain_cnt_q + 2'd1;
                    end
                end
            end
            HALTED: begin
                stall     = 1'b1;
                ex_bubble = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        stall_cycles_d = (stall && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1
                                                                    : stall_cycles_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= RUN;
            drain_cnt_q    <= 2'd0;
            cause_q        <= CAUSE_EBREAK;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            cause_q        <= cause_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Combinational controls read as 0 while reset is held, even with a valid instruction in ID.
    assign o_stall        = i_rst_n && stall;
    assign o_flush        = i_rst_n && flush;
    assign o_ex_bubble    = i_rst_n && ex_bubble;
    assign o_halted       = (state_q == HALTED);
    assign o_trap_cause   = o_halted && cause_q;
    assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with the bypass network and one without,
// driven from shared inputs and reset between scenarios.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, mem_read, illegal, ebreak, redirect;
    logic [4:0]  rs1, rs2, rd;

    logic        stall1, flush1, bub1, halted1, cause1;
    logic [1:0]  fa1, fb1;
    logic [31:0] sc1;
    logic        stall0, flush0, bub0, halted0, cause0;
    logic [1:0]  fa0, fb0;
    logic [31:0] sc0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.BYPASS_EN(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .i_rd_waddr(rd), .i_mem_read(mem_read),
        .i_illegal(illegal), .i_ebreak(ebreak), .i_redirect(redirect),
        .o_stall(stall1), .o_flush(flush1), .o_ex_bubble(bub1),
        .o_fwd_rs1(fa1), .o_fwd_rs2(fb1), .o_halted(halted1),
        .o_trap_cause(cause1), .o_stall_cycles(sc1)
    );

    hazard_ctrl #(.BYPASS_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .i_rd_waddr(rd), .i_mem_read(mem_read),
        .i_illegal(illegal), .i_ebreak(ebreak), .i_redirect(redirect),
        .o_stall(stall0), .o_flush(flush0), .o_ex_bubble(bub0),
        .o_fwd_rs1(fa0), .o_fwd_rs2(fb0), .o_halted(halted0),
        .o_trap_cause(cause0), .o_stall_cycles(sc0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input logic ld, input logic eb,
                         input logic il, input logic rdr);
        id_valid = v;
        rs1      = r1;
        rs2      = r2;
        rd       = d;
        mem_read = ld;
        ebreak   = eb;
        illegal  = il;
        redirect = rdr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic older_three();
        drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    endtask

    initial begin
        // Reset state of both variants
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_stall1", stall1, 0);   check("rst_flush1", flush1, 0);
        check("rst_bub1", bub1, 0);       check("rst_fwd1", {fa1, fb1}, 0);
        check("rst_halt1", {halted1, cause1}, 0); check("rst_sc1", sc1, 0);
        check("rst_stall0", stall0, 0);   check("rst_flush0", flush0, 0);
        check("rst_bub0", bub0, 0);       check("rst_fwd0", {fa0, fb0}, 0);
        check("rst_halt0", {halted0, cause0}, 0); check("rst_sc0", sc0, 0);
        tick();
        rst_n = 1'b1;
        settle();

        // Bypass: lw x5 ; add x6,x5,x1 -> one stall, then WB forward on rs1
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); settle();
        check("lu_prod_stall", stall1, 0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0); settle();
        check("lu_stall", stall1, 1);
        check("lu_bubble", bub1, 1);
        tick();
        settle();
        check("lu_release", stall1, 0);
        check("lu_issue", bub1, 0);
        tick();
        idle(); settle();
        check("lu_fwd_rs1", fa1, 2'b10);
        check("lu_fwd_rs2", fb1, 2'b00);
        check("lu_stall_cycles", sc1, 1);

        // Bypass: addi x5 ; add x6,x5,x5 -> no stall, MEM forward on both operands
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0); settle();
        check("alu_stall", stall1, 0);
        tick();
        idle(); settle();
        check("alu_fwd_rs1", fa1, 2'b01);
        check("alu_fwd_rs2", fb1, 2'b01);

        // No bypass: addi x5 ; add x6,x5,x0 -> three stalls
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("nb_stall", stall0, 1);
            check("nb_fwd_hold", {fa0, fb0}, 0);
            tick();
        end
        settle();
        check("nb_release", stall0, 0);
        check("nb_stall_cycles", sc0, 3);
        tick();
        idle(); settle();
        check("nb_fwd_issue", {fa0, fb0}, 0);

        // x0 never hazards or forwards, even from a load
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
        check("x0_stall1", stall1, 0);
        check("x0_stall0", stall0, 0);
        tick();
        idle(); settle();
        check("x0_fwd1", {fa1, fb1}, 0);
        check("x0_fwd0", {fa0, fb0}, 0);

        // Load-use hazard coinciding with a redirect -> flush, no stall
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1); settle();
        check("rd_flush", flush1, 1);
        check("rd_stall", stall1, 0);
        check("rd_bubble", bub1, 1);
        tick();
        idle(); settle();
        check("rd_ex_empty", dut1.u_sb.ex_rd_q, 0);

        // EBREAK behind three older instructions -> 3 drain cycles then halt
        do_reset();
        older_three();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); settle();
        check("eb_detect_bubble", bub1, 1);
        check("eb_detect_halted", halted1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("eb_drain_stall", stall1, 1);
            check("eb_drain_halted", halted1, 0);
            tick();
        end
        settle();
        check("eb_halted", halted1, 1);
        check("eb_cause", cause1, 0);
        check("eb_stall_cycles", sc1, 3);

        // Redirect in the first drain cycle cancels the trap
        do_reset();
        older_three();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); settle();
        check("wp_flush", flush1, 1);
        check("wp_stall", stall1, 0);
        tick();
        idle();
        repeat (5) tick();
        check("wp_halted", halted1, 0);
        check("wp_run_stall", stall1, 0);

        // Illegal instruction halts with cause 1; redirects are then ignored
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        check("il_halted", halted1, 1);
        check("il_cause", cause1, 1);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); settle();
        check("hl_flush", flush1, 0);
        check("hl_stall", stall1, 1);
        tick();
        check("hl_still_halted", halted1, 1);

        // Reset while halted, inputs still active
        rst_n = 1'b0;
        settle();
        check("hr_stall", stall1, 0);
        check("hr_flush", flush1, 0);
        check("hr_bubble", bub1, 0);
        check("hr_fwd", {fa1, fb1}, 0);
        check("hr_halted", {halted1, cause1}, 0);
        check("hr_sc", sc1, 0);
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        check("hr_run", halted1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
